apb_wrr_arbiter: RTL and testbench

APB_WRR_ARBITER -- requirements
Module: apb_wrr_arbiter

---
 rtl/apb_wrr_arbiter_pkg.sv | 28 ++
 rtl/wrr_rr_pick.sv | 44 ++++
 rtl/apb_wrr_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_apb_wrr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_wrr_arbiter_pkg.sv
// Shared constants for the APB-programmable weighted round-robin arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the register byte addresses, the CTRL/STATUS bit positions and the
// arbiter FSM state type used by apb_wrr_arbiter.
package apb_wrr_arbiter_pkg;

    // Register byte addresses
    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_STATUS      = 8'h04;
    localparam logic [7:0] ADDR_GRANT_CNT   = 8'h08;
    localparam logic [7:0] ADDR_WEIGHT_BASE = 8'h10;  // WEIGHTi at BASE + 4*i

    // CTRL fields
    localparam int CTRL_EN_BIT = 0;

    // STATUS fields
    localparam int STATUS_POP_LSB = 0;   // [7:0]  popcount of req_i
    localparam int STATUS_IDX_LSB = 8;   // [15:8] current grantee index
    localparam int STATUS_ACT_BIT = 16;  // grant active

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating first-one picker: lowest eligible index at or above ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is consumed by the caller in the same cycle.
//
// Ports:
//   elig_i - eligibility mask, one bit per requester
//   ptr_i  - scan start index (0..NUM_REQ-1)
//   pick_o - one-hot selected requester (zero when nothing is eligible)
//   idx_o  - binary index of the selected requester
//   vld_o  - a requester was selected
module wrr_rr_pick #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        int  j;
        logic found;
        j      = 0;
        found  = 1'b0;
        pick_o = '0;
        idx_o  = '0;
        // Visit ptr, ptr+1, ... wrapping at NUM_REQ; first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && elig_i[j]) begin
                found     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = IDX_W'(j);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/apb_wrr_arbiter.sv
// Weighted round-robin arbiter with an APB-style register port (CTRL, STATUS, WEIGHTi).
// Latency: req_i sampled high -> gnt_o high next cycle; PRData_o valid one cycle after a read.
// Backpressure: none; a grant holds for min(weight, request length) and is always
//               followed by exactly one idle cycle before the next grant.
//
// Optional feature: define ARB_GRANT_CNT_EN to add the 32-bit GRANT_CNT register at
// 0x08 (counts grants, saturates, cleared by any write). Without it 0x08 is unmapped.
//
// Ports:
//   Pclk_i, PReset_i             - clock, synchronous active-high reset
//   PSel_i, PWrite_i, PAddr_i,
//   PWData_i, PRData_o           - register access; writes land on the select edge,
//                                  read data is registered and held between reads
//   req_i                        - level requests, one per requester
//   gnt_o                        - registered one-hot-or-zero grant
module apb_wrr_arbiter
    import apb_wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int WEIGHT_W = 4
) (
    input  logic               Pclk_i,
    input  logic               PReset_i,
    input  logic               PSel_i,
    input  logic               PWrite_i,
    input  logic [7:0]         PAddr_i,
    input  logic [31:0]        PWData_i,
    output logic [31:0]        PRData_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Register state
    logic                en_q, en_d;
    logic [WEIGHT_W-1:0] weight_q [NUM_REQ];
    logic [WEIGHT_W-1:0] weight_d [NUM_REQ];
    logic [31:0]         prdata_q, prdata_d;

    // Arbitration state
    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grantee_q, grantee_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;

`ifdef ARB_GRANT_CNT_EN
    logic [31:0]         gcnt_q, gcnt_d;
`endif

    // Decode / datapath
    logic                wr_en, rd_en;
    logic                wt_hit;
    logic [IDX_W-1:0]    wt_idx;
    logic [7:0]          req_pop;
    logic [31:0]         rd_mux;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;
    logic                unused_wdata;

    assign wr_en = PSel_i & PWrite_i;
    assign rd_en = PSel_i & ~PWrite_i;

    // Only some write-data bits are architected; the rest are deliberately ignored.
    assign unused_wdata = ^PWData_i;

    // A zero weight parks a requester without needing a separate mask register.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_i[i] && (weight_q[i] != '0);
        end
    end

    wrr_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // Address decode for the WEIGHT window and live request popcount.
    always_comb begin
        wt_hit  = 1'b0;
        wt_idx  = '0;
        req_pop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PAddr_i == ADDR_WEIGHT_BASE + 8'(4 * i)) begin
                wt_hit = 1'b1;
                wt_idx = IDX_W'(i);
            end
            req_pop = req_pop + 8'(req_i[i]);
        end
    end

    // Read mux; anything not decoded returns zero.
    always_comb begin
        rd_mux = '0;
        if (PAddr_i == ADDR_CTRL) begin
            rd_mux[CTRL_EN_BIT] = en_q;
        end else if (PAddr_i == ADDR_STATUS) begin
            rd_mux[STATUS_POP_LSB +: 8] = req_pop;
            rd_mux[STATUS_IDX_LSB +: 8] = (state_q == ST_GRANT) ? 8'(grantee_q) : 8'h00;
            rd_mux[STATUS_ACT_BIT]      = (state_q == ST_GRANT);
        end
`ifdef ARB_GRANT_CNT_EN
        else if (PAddr_i == ADDR_GRANT_CNT) begin
            rd_mux = gcnt_q;
        end
`endif
        else if (wt_hit) begin
            rd_mux[WEIGHT_W-1:0] = weight_q[wt_idx];
        end
    end

    // Register writes and read-data capture.
    always_comb begin
        en_d = en_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            weight_d[i] = weight_q[i];
        end
        if (wr_en && (PAddr_i == ADDR_CTRL)) begin
            en_d = PWData_i[CTRL_EN_BIT];
        end
        if (wr_en && wt_hit) begin
            weight_d[wt_idx] = PWData_i[WEIGHT_W-1:0];
        end
        prdata_d = rd_en ? rd_mux : prdata_q;
    end

    // Arbitration next state. Credit is latched from the weight at grant start, so
    // weight writes during a grant only affect the next one.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        credit_d  = credit_q;
        ptr_d     = ptr_q;
        grantee_d = grantee_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q && pick_vld) begin
                    state_d   = ST_GRANT;
                    gnt_d     = pick_oh;
                    credit_d  = weight_q[pick_idx];
                    grantee_d = pick_idx;
                end
            end
            ST_GRANT: begin
                credit_d = credit_q - WEIGHT_W'(1);
                // credit==1 means this cycle is the last one the weight allows.
                if (!req_i[grantee_q] || (credit_q == WEIGHT_W'(1)) || !en_q) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    credit_d = '0;
                    ptr_d    = (grantee_q == IDX_W'(NUM_REQ - 1)) ? '0 : grantee_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

`ifdef ARB_GRANT_CNT_EN
    // A write clears the counter even if a grant starts on the same edge.
    always_comb begin
        gcnt_d = gcnt_q;
        if (wr_en && (PAddr_i == ADDR_GRANT_CNT)) begin
            gcnt_d = '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_GRANT) && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge Pclk_i) begin
        if (PReset_i) begin
            en_q      <= 1'b0;
            prdata_q  <= '0;
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grantee_q <= '0;
            credit_q  <= '0;
            gnt_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                weight_q[i] <= WEIGHT_W'(1);
            end
`ifdef ARB_GRANT_CNT_EN
            gcnt_q    <= '0;
`endif
        end else begin
            en_q      <= en_d;
            prdata_q  <= prdata_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grantee_q <= grantee_d;
            credit_q  <= credit_d;
            gnt_q     <= gnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                weight_q[i] <= weight_d[i];
            end
`ifdef ARB_GRANT_CNT_EN
            gcnt_q    <= gcnt_d;
`endif
        end
    end

    assign gnt_o    = gnt_q;
    assign PRData_o = prdata_q;

endmodule

// File: tb/tb_apb_wrr_arbiter.sv
// Testbench for apb_wrr_arbiter (NUM_REQ=8, WEIGHT_W=4).
// Directed scenarios with fixed expected sequences, then randomized traffic
// compared cycle by cycle against a grant-level reference model.
module tb_apb_wrr_arbiter;

    localparam int N  = 8;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel = 1'b0;
    logic          pwrite = 1'b0;
    logic [7:0]    paddr = 8'h00;
    logic [31:0]   pwdata = 32'h0;
    logic [31:0]   prdata;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;

    always #5 clk = ~clk;

    apb_wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
        .Pclk_i   (clk),
        .PReset_i (rst),
        .PSel_i   (psel),
        .PWrite_i (pwrite),
        .PAddr_i  (paddr),
        .PWData_i (pwdata),
        .PRData_o (prdata),
        .req_i    (req),
        .gnt_o    (gnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a grant is "requester g, budget b, held h cycles so far".
    bit           m_en;
    int           m_w [N];
    int           m_ptr;
    bit           m_act;
    int           m_g;
    int           m_held;
    int           m_budget;
    logic [31:0]  m_cnt;
    logic [N-1:0] m_gnt;
    logic [31:0]  m_rdata;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r;
        int pop;
        r   = '0;
        pop = 0;
        for (int i = 0; i < N; i++) pop += int'(req[i]);
        if (a == 8'h00) begin
            r[0] = m_en;
        end else if (a == 8'h04) begin
            r[7:0]  = pop[7:0];
            r[15:8] = m_act ? m_g[7:0] : 8'h00;
            r[16]   = m_act;
        end else if (a == 8'h08) begin
`ifdef ARB_GRANT_CNT_EN
            r = m_cnt;
`else
            r = '0;
`endif
        end else if (a >= 8'h10 && int'(a) < 16 + 4 * N && a[1:0] == 2'b00) begin
            r[WW-1:0] = m_w[int'(a - 8'h10) / 4][WW-1:0];
        end
        return r;
    endfunction

    // One clock edge: advance the model with the inputs the DUT samples, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_en = 1'b0;
            for (int i = 0; i < N; i++) m_w[i] = 1;
            m_ptr = 0; m_act = 1'b0; m_g = 0; m_held = 0; m_budget = 0;
            m_cnt = '0; m_rdata = '0;
        end else begin
            if (psel && !pwrite) m_rdata = model_read(paddr);
            if (m_act) begin
                m_held++;
                if (!req[m_g] || m_held >= m_budget || !m_en) begin
                    m_act = 1'b0;
                    m_ptr = (m_g + 1) % N;
                end
            end else if (m_en) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (!m_act && req[i] && m_w[i] != 0) begin
                        m_act = 1'b1; m_g = i; m_budget = m_w[i]; m_held = 0;
                        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                    end
                end
            end
            if (psel && pwrite) begin
                if (paddr == 8'h00) m_en = pwdata[0];
`ifdef ARB_GRANT_CNT_EN
                else if (paddr == 8'h08) m_cnt = '0;
`endif
                else if (paddr >= 8'h10 && int'(paddr) < 16 + 4 * N && paddr[1:0] == 2'b00)
                    m_w[int'(paddr - 8'h10) / 4] = int'(pwdata[WW-1:0]);
            end
        end
        m_gnt = '0;
        if (m_act) m_gnt[m_g] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; psel = 1'b0; pwrite = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        psel = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a);
        psel = 1'b1; pwrite = 1'b0; paddr = a;
        tick();
        psel = 1'b0;
    endtask

    task automatic test_reset();
        req = 8'hFF; rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00) begin failures++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
        checks++;
        if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        rst = 1'b0;
        apb_read(8'h00);
        checks++;
        if (prdata !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h expected 0", prdata); end
        for (int i = 0; i < N; i++) begin
            apb_read(8'(16 + 4 * i));
            checks++;
            if (prdata !== 32'h1) begin
                failures++; $display("FAIL reset_weight%0d: got %h expected 1", i, prdata);
            end
        end
    endtask

    task automatic test_disabled();
        req = 8'hFF;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (gnt !== 8'h00) begin failures++; $display("FAIL disabled_gnt: got %h expected 00", gnt); end
        end
        apb_read(8'h04);
        checks++;
        if (prdata !== 32'h0000_0008) begin
            failures++; $display("FAIL disabled_status: got %h expected 00000008", prdata);
        end
    endtask

    task automatic test_equal_weights();
        logic [7:0] exp;
        req = 8'hFF;
        do_reset();
        apb_write(8'h00, 32'h1);
        for (int k = 0; k < 17; k++) begin
            tick();
            exp = (k % 2 == 0) ? (8'h01 << ((k / 2) % 8)) : 8'h00;
            checks++;
            if (gnt !== exp) begin
                failures++; $display("FAIL equal_wt_cycle%0d: got %h expected %h", k, gnt, exp);
            end
        end
    endtask

    task automatic test_unequal_weights();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h01, 8'h01};
        req = 8'h03;
        do_reset();
        apb_write(8'h10, 32'd3);
        apb_write(8'h14, 32'd1);
        apb_write(8'h00, 32'h1);
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (gnt !== exp_seq[k]) begin
                failures++; $display("FAIL unequal_wt_cycle%0d: got %h expected %h", k, gnt, exp_seq[k]);
            end
        end
    endtask

    task automatic test_zero_weight();
        int held;
        req = 8'h04;
        do_reset();
        apb_write(8'h18, 32'd0);
        apb_write(8'h00, 32'h1);
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (gnt !== 8'h00) begin failures++; $display("FAIL zero_wt_gnt: got %h expected 00", gnt); end
        end
        apb_write(8'h18, 32'd2);
        for (int k = 0; k < 2 && gnt !== 8'h04; k++) tick();
        checks++;
        if (gnt !== 8'h04) begin failures++; $display("FAIL zero_wt_regrant: got %h expected 04", gnt); end
        held = 0;
        for (int k = 0; k < 10 && gnt === 8'h04; k++) begin
            held++;
            tick();
        end
        checks++;
        if (held != 2) begin failures++; $display("FAIL zero_wt_hold: got %0d cycles expected 2", held); end
    endtask

    task automatic test_early_drop_reset();
        req = 8'h03;
        do_reset();
        apb_write(8'h10, 32'd5);
        apb_write(8'h00, 32'h1);
        tick();
        checks++;
        if (gnt !== 8'h01) begin failures++; $display("FAIL drop_first: got %h expected 01", gnt); end
        tick();
        checks++;
        if (gnt !== 8'h01) begin failures++; $display("FAIL drop_second: got %h expected 01", gnt); end
        req = 8'h02;
        tick();
        checks++;
        if (gnt !== 8'h00) begin failures++; $display("FAIL drop_release: got %h expected 00", gnt); end
        tick();
        checks++;
        if (gnt !== 8'h02) begin failures++; $display("FAIL drop_next: got %h expected 02", gnt); end
        req = 8'h01;
        tick(); tick();
        checks++;
        if (gnt !== 8'h01) begin failures++; $display("FAIL rst_pre: got %h expected 01", gnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00) begin failures++; $display("FAIL rst_midgrant: got %h expected 00", gnt); end
        rst = 1'b0;
    endtask

    task automatic test_weight_midgrant();
        int held;
        req = 8'h01;
        do_reset();
        apb_write(8'h10, 32'd4);
        apb_write(8'h00, 32'h1);
        tick();
        apb_write(8'h10, 32'd1);
        held = 2;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (gnt === 8'h01) held++;
            else break;
        end
        checks++;
        if (held != 4) begin failures++; $display("FAIL midgrant_len: got %0d cycles expected 4", held); end
        tick();
        checks++;
        if (gnt !== 8'h01) begin failures++; $display("FAIL midgrant_next: got %h expected 01", gnt); end
        tick();
        checks++;
        if (gnt !== 8'h00) begin failures++; $display("FAIL midgrant_newlen: got %h expected 00", gnt); end
    endtask

    task automatic test_grant_cnt();
        int n;
        logic [N-1:0] prev;
        req = 8'hFF;
        do_reset();
        apb_write(8'h00, 32'h1);
        n = 0; prev = '0;
        for (int k = 0; k < 60 && n < 10; k++) begin
            tick();
            if (gnt !== '0 && prev === '0) n++;
            prev = gnt;
        end
        req = '0;
        checks++;
        if (n != 10) begin failures++; $display("FAIL cnt_grants_seen: got %0d expected 10", n); end
        tick(); tick();
        apb_read(8'h08);
`ifdef ARB_GRANT_CNT_EN
        checks++;
        if (prdata !== 32'd10) begin failures++; $display("FAIL cnt_value: got %h expected 0000000a", prdata); end
        apb_write(8'h08, 32'h1234_5678);
        apb_read(8'h08);
        checks++;
        if (prdata !== 32'd0) begin failures++; $display("FAIL cnt_clear: got %h expected 0", prdata); end
`else
        checks++;
        if (prdata !== 32'd0) begin failures++; $display("FAIL cnt_unmapped: got %h expected 0", prdata); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] addr_list [16];
        int r;
        addr_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                      8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h11, 8'h40, 8'hFF};
        do_reset();
        for (int i = 0; i < N; i++) apb_write(8'(16 + 4 * i), 32'($urandom_range(0, 5)));
        apb_write(8'h00, 32'h1);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            r = $urandom_range(0, 11);
            rst = ($urandom_range(0, 299) == 0);
            if (r <= 3) begin
                psel = 1'b1; pwrite = 1'b0; paddr = addr_list[$urandom_range(0, 15)];
            end else if (r == 4) begin
                psel = 1'b1; pwrite = 1'b1; paddr = 8'(16 + 4 * $urandom_range(0, N - 1));
                pwdata = $urandom;
            end else if (r == 5) begin
                psel = 1'b1; pwrite = 1'b1; paddr = 8'h00;
                pwdata = {$urandom_range(0, 1 << 30), 1'b0} | 32'($urandom_range(0, 5) != 0);
            end else if (r == 6) begin
                psel = 1'b1; pwrite = 1'b1; paddr = addr_list[$urandom_range(0, 15)];
                pwdata = $urandom;
                if (paddr == 8'h00) pwdata[0] = 1'b1;
            end else begin
                psel = 1'b0; pwrite = 1'b0;
            end
            tick();
            psel = 1'b0; pwrite = 1'b0; rst = 1'b0;
            checks++;
            if (gnt !== m_gnt) begin
                failures++; $display("FAIL rand_gnt cycle %0d: got %h expected %h", k, gnt, m_gnt);
            end
            checks++;
            if (prdata !== m_rdata) begin
                failures++; $display("FAIL rand_prdata cycle %0d: got %h expected %h", k, prdata, m_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_equal_weights();
        test_unequal_weights();
        test_zero_weight();
        test_early_drop_reset();
        test_weight_midgrant();
        test_grant_cnt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
